mult_booth_r4: RTL

// - Sequential radix-4 Booth multiplier; successor to the shift-add multiplier with the same
//   en_pi / busy_o / c_vld_o protocol and tc_mode_i signedness control.
// - Retires 2 multiplier bits per cycle, so latency is about half that of the shift-add block.
// - Adds abort_i and an optional early-termination mode.
// - Used by datapath blocks that need a compact, multi-cycle multiply with mixed signedness.

---
 rtl/mult_booth_r4.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mult_booth_r4.sv
// Sequential radix-4 Booth multiplier with mixed signedness and abort.
// One Booth digit (two multiplier bits) is retired per CALC cycle.
// Optional early termination is enabled by defining MULT_EARLY_TERM_EN.
// The default build has the feature disabled and runs a fixed N CALC cycles.

module mult_booth_r4 #(
  parameter int unsigned A_DW = 8,
  parameter int unsigned B_DW = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           tc_mode_i,
  input  logic                 en_pi,
  input  logic                 abort_i,
  input  logic [A_DW-1:0]      a_i,
  input  logic [B_DW-1:0]      b_i,
  output logic                 busy_o,
  output logic                 c_vld_o,
  output logic [A_DW+B_DW-1:0] c_o
);

  localparam int unsigned CW    = A_DW + B_DW;
  localparam int unsigned N     = (B_DW + 2) / 2;
  // Extended multiplicand covers +-2a.
  localparam int unsigned AEW   = A_DW + 2;
  // One extra headroom bit: running sum plus a +-2a digit must not wrap.
  localparam int unsigned HW    = A_DW + 3;
  localparam int unsigned AW    = HW + 2 * N;
  // Multiplier register keeps the implicit zero below the LSB at bit 0.
  localparam int unsigned BW    = 2 * N + 1;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_t;

  state_t            state_q, state_d;
  logic [AEW-1:0]    a_q;
  logic [BW-1:0]     b_q;
  logic [AW-1:0]     acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CW-1:0]     c_q;

  logic [AEW-1:0]    a_ext;
  logic [2*N-1:0]    b_ext;
  logic [HW-1:0]     a_h;
  logic [HW-1:0]     pp;
  logic [HW-1:0]     hi_sum;
  logic [AW-1:0]     acc_sum;
  logic [AW-1:0]     acc_shift;
  int unsigned       shamt;
  logic              last;
  logic              start;
  logic              step;
  logic              load_c;
`ifdef MULT_EARLY_TERM_EN
  logic              rem_eq;
`endif

  assign a_ext = {{2{tc_mode_i[0] & a_i[A_DW-1]}}, a_i};
  assign b_ext = {{(2*N-B_DW){tc_mode_i[1] & b_i[B_DW-1]}}, b_i};

  // Booth digit decode, partial-product add into the upper bits, then arithmetic shift.
  always_comb begin
    a_h = {a_q[AEW-1], a_q};
    unique case (b_q[2:0])
      3'b001, 3'b010: pp = a_h;
      3'b011:         pp = a_h << 1;
      3'b100:         pp = -(a_h << 1);
      3'b101, 3'b110: pp = -a_h;
      default:        pp = '0;
    endcase
    hi_sum  = acc_q[AW-1 -: HW] + pp;
    acc_sum = {hi_sum, acc_q[2*N-1:0]};
`ifdef MULT_EARLY_TERM_EN
    // All remaining multiplier bits equal (overlap bit included) means every
    // later digit is zero, so the outstanding shifts are applied at once.
    rem_eq = (b_q[BW-1:2] == '0) || (b_q[BW-1:2] == '1);
    last   = rem_eq || (cnt_q == CNT_W'(N - 1));
    shamt  = rem_eq ? 2 * (N - 32'(cnt_q)) : 32'd2;
`else
    last   = (cnt_q == CNT_W'(N - 1));
    shamt  = 32'd2;
`endif
    acc_shift = $signed(acc_sum) >>> shamt;
  end

  // Next-state and control decode; abort has priority over completion in CALC.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    load_c  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_pi) begin
          state_d = StCalc;
          start   = 1'b1;
        end
      end
      StCalc: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          step = 1'b1;
          if (last) begin
            state_d = StDone;
            load_c  = 1'b1;
          end
        end
      end
      StDone: begin
        if (en_pi) begin
          state_d = StCalc;
          start   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch on start, one digit retired per CALC step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= a_ext;
      b_q   <= {b_ext, 1'b0};
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_shift;
      b_q   <= $signed(b_q) >>> 2;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Product register, loaded on the edge into DONE and held until the next result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q <= '0;
    end else if (load_c) begin
      c_q <= acc_shift[CW-1:0];
    end
  end

  assign busy_o  = (state_q == StCalc);
  assign c_vld_o = (state_q == StDone);
  assign c_o     = c_q;

endmodule
